// File: rtl/spi_dev_lcdpalwr_v2_if.sv
// Bus bundle for the palette LCD writer: SPI wrapper byte bus in, LCD PHY byte stream out.
interface spi_dev_lcdpalwr_v2_if;
    logic [7:0] pw_wdata;
    logic       pw_wcmd;
    logic       pw_wstb;
    logic       pw_end;
    logic [7:0] phy_data;
    logic       phy_rs;
    logic       phy_valid;
    logic       phy_ready;
    logic       status_ovf;

    modport master (
        output pw_wdata, pw_wcmd, pw_wstb, pw_end, phy_ready,
        input  phy_data, phy_rs, phy_valid, status_ovf
    );

    modport slave (
        input  pw_wdata, pw_wcmd, pw_wstb, pw_end, phy_ready,
        output phy_data, phy_rs, phy_valid, status_ovf
    );
endinterface

// File: rtl/spi_dev_lcdpalwr_v2.sv
// Palette-lookup LCD writer: loads a 256-entry RGB565 palette, unpacks pixel indices, streams colours MSB-byte-first.
// Optional macro SPI_LCDPALWR_OVF_EN builds the sticky dropped-byte flag; otherwise status_ovf is tied low.
module spi_dev_lcdpalwr_v2 #(
    parameter logic [7:0] CMD_BYTE  = 8'he4,
    parameter int         BPP       = 8,
    parameter int         FIFO_LOG2 = 3
) (
    input logic                  clk,
    input logic                  rst,
    spi_dev_lcdpalwr_v2_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int IPB   = 8 / BPP;
    localparam int LW    = FIFO_LOG2 + 1;

    logic w_cmd_stb;
    logic w_data_stb;
    logic w_start;
    logic w_issue;
    logic w_hold_free;
    logic w_px_stb;
    logic w_accept;
    logic w_push;
    logic w_hs;
    logic w_pop;
    logic [7:0] w_idx;

    logic r_active_wr;
    logic r_active_pal;
    logic [8:0] r_pal_waddr;
    logic [7:0] r_pal_hi [256];
    logic [7:0] r_pal_lo [256];
    logic [7:0] r_hold;
    logic [3:0] r_cnt;
    logic [15:0] r_rd_data;
    logic r_rd_vld;
    logic [15:0] r_fifo [DEPTH];
    logic [FIFO_LOG2-1:0] r_wptr;
    logic [FIFO_LOG2-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic r_bsel;

    assign w_cmd_stb  = bus.pw_wstb & bus.pw_wcmd;
    assign w_data_stb = bus.pw_wstb & ~bus.pw_wcmd;
    assign w_start    = w_cmd_stb & (bus.pw_wdata[7:1] == CMD_BYTE[7:1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active_wr  <= 1'b0;
            r_active_pal <= 1'b0;
        end else if (bus.pw_end) begin
            r_active_wr  <= 1'b0;
            r_active_pal <= 1'b0;
        end else if (w_start) begin
            r_active_wr  <= ~bus.pw_wdata[0];
            r_active_pal <= bus.pw_wdata[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pal_waddr <= 9'd0;
        end else if (w_cmd_stb) begin
            r_pal_waddr <= 9'd0;
        end else if (w_data_stb) begin
            r_pal_waddr <= r_pal_waddr + 9'd1;
        end
    end

    // Even byte addresses hold the colour high byte, odd ones the low byte.
    always_ff @(posedge clk) begin
        if (r_active_pal && w_data_stb && !r_pal_waddr[0]) begin
            r_pal_hi[r_pal_waddr[8:1]] <= bus.pw_wdata;
        end
        if (r_active_pal && w_data_stb && r_pal_waddr[0]) begin
            r_pal_lo[r_pal_waddr[8:1]] <= bus.pw_wdata;
        end
        if (w_issue) begin
            r_rd_data <= {r_pal_hi[w_idx], r_pal_lo[w_idx]};
        end
        if (w_push) begin
            r_fifo[r_wptr] <= r_rd_data;
        end
    end

    // Reserve a FIFO slot for the lookup still in flight so a push can never land on a full FIFO.
    assign w_idx       = 8'(r_hold[7 -: BPP]);
    assign w_issue     = (r_cnt != 4'd0) && ((int'(r_level) + int'(r_rd_vld)) < DEPTH);
    assign w_hold_free = (r_cnt == 4'd0) || ((r_cnt == 4'd1) && w_issue);
    assign w_px_stb    = r_active_wr & w_data_stb;
    assign w_accept    = w_px_stb & w_hold_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= 8'd0;
            r_cnt  <= 4'd0;
        end else if (w_accept) begin
            r_hold <= bus.pw_wdata;
            r_cnt  <= 4'(IPB);
        end else if (w_issue) begin
            r_hold <= r_hold << BPP;
            r_cnt  <= r_cnt - 4'd1;
        end
    end

    assign w_push = r_rd_vld;
    assign w_hs   = bus.phy_valid & bus.phy_ready;
    assign w_pop  = w_hs & r_bsel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_vld <= 1'b0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_bsel   <= 1'b0;
        end else begin
            r_rd_vld <= w_issue;
            if (w_push) begin
                r_wptr <= r_wptr + FIFO_LOG2'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + FIFO_LOG2'(1);
            end
            if (w_hs) begin
                r_bsel <= ~r_bsel;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign bus.phy_valid = (r_level != '0);
    assign bus.phy_data  = r_bsel ? r_fifo[r_rptr][7:0] : r_fifo[r_rptr][15:8];
    assign bus.phy_rs    = 1'b1;

`ifdef SPI_LCDPALWR_OVF_EN
    logic w_drop;
    logic r_ovf;

    assign w_drop = w_px_stb & ~w_hold_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_start) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    assign bus.status_ovf = r_ovf;
`else
    assign bus.status_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_spi_dev_lcdpalwr_v2.sv
// Randomised bench for spi_dev_lcdpalwr_v2 against a queue-based palette/pixel/byte-stream model.
module tb_spi_dev_lcdpalwr_v2;
    localparam logic [7:0] CMD = 8'he4;
    localparam int BPP       = 2;
    localparam int FIFO_LOG2 = 2;
    localparam int DEPTH     = 1 << FIFO_LOG2;
    localparam int IPB       = 8 / BPP;
`ifdef SPI_LCDPALWR_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   errorCount = 0;
    int   readyMode  = 1;

    spi_dev_lcdpalwr_v2_if bus();

    spi_dev_lcdpalwr_v2 #(
        .CMD_BYTE (CMD),
        .BPP      (BPP),
        .FIFO_LOG2(FIFO_LOG2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model state: palette contents, indices not yet looked up, colours queued for the PHY.
    logic [15:0] mPal [256];
    logic [8:0]  mWaddr = 9'd0;
    bit          mActWr = 1'b0;
    bit          mActPal = 1'b0;
    bit          mBsel = 1'b0;
    bit          mOvf = 1'b0;
    bit          mInflight = 1'b0;
    logic [15:0] mInflightColour = 16'h0;
    logic [15:0] mFifo [$];
    logic [7:0]  mPend [$];
    logic [7:0]  gotQ [$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic modelStep();
        bit hs;
        bit issue;
        bit free;
        int b;
        logic [15:0] col;
        col   = 16'h0;
        hs    = (mFifo.size() > 0) && (bus.phy_ready === 1'b1);
        issue = (mPend.size() > 0) && ((mFifo.size() + int'(mInflight)) < DEPTH);
        if (issue) col = mPal[mPend[0]];
        free = (mPend.size() == 0) || (mPend.size() == 1 && issue);
        if (hs) begin
            if (mBsel) begin
                void'(mFifo.pop_front());
                mBsel = 1'b0;
            end else begin
                mBsel = 1'b1;
            end
        end
        if (mInflight) mFifo.push_back(mInflightColour);
        mInflight       = issue;
        mInflightColour = col;
        if (issue) void'(mPend.pop_front());
        if (bus.pw_wstb && !bus.pw_wcmd) begin
            if (mActPal) begin
                if (mWaddr[0]) mPal[mWaddr[8:1]][7:0] = bus.pw_wdata;
                else           mPal[mWaddr[8:1]][15:8] = bus.pw_wdata;
            end
            if (mActWr) begin
                b = int'(bus.pw_wdata);
                if (free) begin
                    for (int k = 0; k < IPB; k++)
                        mPend.push_back(8'((b / (1 << (8 - BPP * (k + 1)))) % (1 << BPP)));
                end else if (OVF_ON) begin
                    mOvf = 1'b1;
                end
            end
            mWaddr = mWaddr + 9'd1;
        end
        if (bus.pw_wstb && bus.pw_wcmd) begin
            mWaddr = 9'd0;
            if (bus.pw_wdata[7:1] == CMD[7:1]) begin
                mOvf = 1'b0;
                if (!bus.pw_end) begin
                    mActWr  = !bus.pw_wdata[0];
                    mActPal = bus.pw_wdata[0];
                end
            end
        end
        if (bus.pw_end) begin
            mActWr  = 1'b0;
            mActPal = 1'b0;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mWaddr    = 9'd0;
            mActWr    = 1'b0;
            mActPal   = 1'b0;
            mBsel     = 1'b0;
            mOvf      = 1'b0;
            mInflight = 1'b0;
            mFifo.delete();
            mPend.delete();
        end else begin
            modelStep();
        end
    end

    // Outputs are checked mid-cycle; accepted PHY bytes are also logged for literal stream checks.
    always @(negedge clk) begin
        checkOutput("phy_valid", bus.phy_valid, mFifo.size() > 0);
        if (mFifo.size() > 0)
            checkOutput("phy_data", bus.phy_data, mBsel ? mFifo[0][7:0] : mFifo[0][15:8]);
        checkOutput("phy_rs", bus.phy_rs, 1);
        checkOutput("status_ovf", bus.status_ovf, mOvf);
        if (bus.phy_valid === 1'b1 && bus.phy_ready === 1'b1) gotQ.push_back(bus.phy_data);
    end

    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       bus.phy_ready = 1'b0;
            1:       bus.phy_ready = 1'b1;
            2:       bus.phy_ready = (bus.phy_ready === 1'b1) ? 1'b0 : 1'b1;
            default: bus.phy_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit isCmd, input logic [7:0] data);
        bus.pw_wdata = data;
        bus.pw_wcmd  = isCmd;
        bus.pw_wstb  = 1'b1;
        tick();
        bus.pw_wstb  = 1'b0;
        bus.pw_wcmd  = 1'b0;
    endtask

    task automatic sendEnd();
        bus.pw_end = 1'b1;
        tick();
        bus.pw_end = 1'b0;
    endtask

    task automatic waitDrain(input int limit);
        int n = 0;
        while ((mFifo.size() > 0 || mPend.size() > 0 || mInflight) && n < limit) begin
            tick();
            n++;
        end
        if (mFifo.size() > 0 || mPend.size() > 0 || mInflight)
            checkOutput("drain_timeout", 1, 0);
    endtask

    task automatic checkStream(input string name, input logic [7:0] e [8]);
        checkOutput({name, "_len"}, gotQ.size(), 8);
        for (int i = 0; i < 8 && i < gotQ.size(); i++)
            checkOutput(name, gotQ[i], e[i]);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        errorCount++;
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] e [8];
        int r;
        int n;
        bus.pw_wdata = 8'h00;
        bus.pw_wcmd  = 1'b0;
        bus.pw_wstb  = 1'b0;
        bus.pw_end   = 1'b0;
        rst = 1'b1;
        tick(3);
        checkOutput("reset_valid", bus.phy_valid, 0);
        checkOutput("reset_ovf", bus.status_ovf, 0);
        rst = 1'b0;
        tick();

        // Palette load, then first-colour latency from the pixel strobe.
        applyStimulus(1, CMD | 8'h01);
        applyStimulus(0, 8'h12);
        applyStimulus(0, 8'h34);
        applyStimulus(0, 8'hAB);
        applyStimulus(0, 8'hCD);
        sendEnd();
        applyStimulus(1, CMD);
        gotQ.delete();
        applyStimulus(0, 8'h01);
        checkOutput("latency_c1", bus.phy_valid, 0);
        tick();
        checkOutput("latency_c2", bus.phy_valid, 0);
        tick();
        checkOutput("latency_c3", bus.phy_valid, 1);
        waitDrain(100);
        e = '{8'h12, 8'h34, 8'h12, 8'h34, 8'h12, 8'h34, 8'hAB, 8'hCD};
        checkStream("pal_load", e);

        sendEnd();
        applyStimulus(1, CMD | 8'h01);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 8'(k * 8'h11));
            applyStimulus(0, 8'(k * 8'h11));
        end
        sendEnd();
        applyStimulus(1, CMD);
        gotQ.delete();
        applyStimulus(0, 8'b00_01_10_11);
        waitDrain(100);
        e = '{8'h00, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
        checkStream("unpack", e);

        readyMode = 0;
        tick();
        gotQ.delete();
        applyStimulus(0, 8'b00_01_10_11);
        tick(20);
        checkOutput("stall_valid", bus.phy_valid, 1);
        checkOutput("stall_nobytes", gotQ.size(), 0);
        readyMode = 2;
        waitDrain(200);
        checkStream("backpressure", e);

        // Second byte arrives while three indices of the first are still unissued.
        readyMode = 0;
        sendEnd();
        applyStimulus(1, CMD);
        tick();
        gotQ.delete();
        applyStimulus(0, 8'b00_01_10_11);
        tick();
        applyStimulus(0, 8'hFF);
        checkOutput("ovf_set", bus.status_ovf, OVF_ON);
        tick(10);
        readyMode = 1;
        waitDrain(200);
        tick(3);
        checkStream("overflow", e);
        checkOutput("ovf_sticky", bus.status_ovf, OVF_ON);
        applyStimulus(1, CMD);
        checkOutput("ovf_clear", bus.status_ovf, 0);

        sendEnd();
        applyStimulus(1, CMD | 8'h01);
        for (int k = 0; k < 514; k++)
            applyStimulus(0, (k == 512) ? 8'hC3 : (k == 513) ? 8'h3C : 8'(k));
        sendEnd();
        applyStimulus(1, CMD);
        gotQ.delete();
        applyStimulus(0, 8'b00_01_00_00);
        waitDrain(100);
        e = '{8'hC3, 8'h3C, 8'h02, 8'h03, 8'hC3, 8'h3C, 8'hC3, 8'h3C};
        checkStream("wrap", e);

        gotQ.delete();
        applyStimulus(0, 8'b11_10_01_00);
        sendEnd();
        applyStimulus(0, 8'h55);
        waitDrain(100);
        tick(3);
        e = '{8'h06, 8'h07, 8'h04, 8'h05, 8'h02, 8'h03, 8'hC3, 8'h3C};
        checkStream("end_drain", e);

        readyMode = 0;
        applyStimulus(1, CMD);
        applyStimulus(0, 8'b00_01_10_11);
        tick(5);
        readyMode = 1;
        tick(2);
        rst = 1'b1;
        #1;
        checkOutput("rst_async_valid", bus.phy_valid, 0);
        tick(2);
        rst = 1'b0;
        gotQ.delete();
        applyStimulus(0, 8'hFF);
        tick(20);
        checkOutput("rst_no_bytes", gotQ.size(), 0);
        checkOutput("rst_valid_low", bus.phy_valid, 0);

        applyStimulus(1, CMD);
        for (int it = 0; it < 400; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) begin
                applyStimulus(0, 8'($urandom));
                tick(int'($urandom_range(0, 5)));
            end else if (r < 80) begin
                readyMode = int'($urandom_range(0, 3));
            end else if (r < 88) begin
                sendEnd();
                applyStimulus(1, CMD);
            end else if (r < 92) begin
                readyMode = 1;
                waitDrain(300);
                sendEnd();
                applyStimulus(1, CMD | 8'h01);
                n = int'($urandom_range(1, 40));
                for (int k = 0; k < n; k++) applyStimulus(0, 8'($urandom));
                sendEnd();
                applyStimulus(1, CMD);
            end else begin
                tick(int'($urandom_range(1, 8)));
            end
        end
        readyMode = 1;
        waitDrain(500);
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
